rv32_mc_ctrl: RTL and testbench

Multi-cycle control unit for the RV32I datapath. It drives the ALU's `ALUctr` code and operand selects and consumes the ALU's `less`/`zero` flags to resolve branches. It fetches instructions through a valid/ready handshake and sequences register-file, memory and PC writes through a fixed state machine. It sits between instruction memory and the datapath, on the producing side of the ALU control interface.

---
 rtl/rv32_ctrl_pkg.sv | 77 +++++++
 rtl/rv32_alu_dec.sv | 65 ++++++
 rtl/rv32_mc_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_rv32_mc_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller.
// ALU codes, opcodes, operand/PC selects and the FSM state enum.
package rv32_ctrl_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_SRCB = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_U = 3'b001;
    localparam logic [2:0] EXT_S = 3'b010;
    localparam logic [2:0] EXT_B = 3'b011;
    localparam logic [2:0] EXT_J = 3'b100;

    localparam logic [1:0] PC_4   = 2'b00;
    localparam logic [1:0] PC_IMM = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;

    localparam logic [1:0] BSRC_RS2 = 2'b00;
    localparam logic [1:0] BSRC_IMM = 2'b01;
    localparam logic [1:0] BSRC_4   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    // funct3 (+ alternate bit) to ALU operation for R/I arithmetic
    function automatic logic [3:0] alu_fn(input logic [2:0] f3,
                                          input logic alt);
        logic [3:0] r;
        r = ALU_ADD;
        case (f3)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    function automatic logic op_known(input logic [6:0] op);
        return (op == OP_R)     || (op == OP_I)     ||
               (op == OP_LUI)   || (op == OP_AUIPC) ||
               (op == OP_JAL)   || (op == OP_JALR)  ||
               (op == OP_LOAD)  || (op == OP_STORE) ||
               (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/rv32_alu_dec.sv
// Opcode/funct3/instr[30] to ALU code, operand selects and
// immediate format. Unknown opcodes decode to all zeros.
module rv32_alu_dec
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       alt,
    output logic [3:0] alu_ctr,
    output logic       alu_asrc,
    output logic [1:0] alu_bsrc,
    output logic [2:0] ext_op
);

    // per-opcode operation and operand routing
    always_comb begin
        alu_ctr  = ALU_ADD;
        alu_asrc = 1'b0;
        alu_bsrc = BSRC_RS2;
        ext_op   = EXT_I;
        case (opcode)
            OP_R: begin
                alu_ctr = alu_fn(funct3, alt);
            end
            OP_I: begin
                alu_ctr  = alu_fn(funct3, alt & (funct3 == 3'b101));
                alu_bsrc = BSRC_IMM;
            end
            OP_LUI: begin
                alu_ctr  = ALU_SRCB;
                alu_bsrc = BSRC_IMM;
                ext_op   = EXT_U;
            end
            OP_AUIPC: begin
                alu_asrc = 1'b1;
                alu_bsrc = BSRC_IMM;
                ext_op   = EXT_U;
            end
            OP_JAL: begin
                alu_asrc = 1'b1;
                alu_bsrc = BSRC_4;
                ext_op   = EXT_J;
            end
            OP_JALR: begin
                alu_asrc = 1'b1;
                alu_bsrc = BSRC_4;
            end
            OP_LOAD: begin
                alu_bsrc = BSRC_IMM;
            end
            OP_STORE: begin
                alu_bsrc = BSRC_IMM;
                ext_op   = EXT_S;
            end
            OP_BRANCH: begin
                alu_ctr = funct3[1] ? ALU_SLTU : ALU_SLT;
                ext_op  = EXT_B;
            end
            default: begin
                alu_ctr = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/rv32_mc_ctrl.sv
// Multi-cycle RV32I control unit: fetch handshake, FSM, strobes.
// Define RV32_MC_CTRL_TRAP_EN to trap on unknown opcodes.
module rv32_mc_ctrl
    import rv32_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        mem_done,
    input  logic        less,
    input  logic        zero,
    output logic [3:0]  alu_ctr,
    output logic        alu_asrc,
    output logic [1:0]  alu_bsrc,
    output logic [2:0]  ext_op,
    output logic        reg_wr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_to_reg,
    output logic [2:0]  mem_op,
    output logic        pc_wr,
    output logic [1:0]  pc_src,
    output logic        busy,
    output logic        trap
);

    state_t     state;
    logic [6:0] ir_op;
    logic [2:0] ir_f3;
    logic       ir_alt;

    // register/rs/imm fields belong to the datapath, not to us
    logic unused_instr;
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    logic [3:0] dec_ctr;
    logic       dec_asrc;
    logic [1:0] dec_bsrc;
    logic [2:0] dec_ext;

    rv32_alu_dec u_dec (
        .opcode   (ir_op),
        .funct3   (ir_f3),
        .alt      (ir_alt),
        .alu_ctr  (dec_ctr),
        .alu_asrc (dec_asrc),
        .alu_bsrc (dec_bsrc),
        .ext_op   (dec_ext)
    );

    logic is_load, is_store, is_br, is_jal, is_jalr, known;
    assign is_load  = (ir_op == OP_LOAD);
    assign is_store = (ir_op == OP_STORE);
    assign is_br    = (ir_op == OP_BRANCH);
    assign is_jal   = (ir_op == OP_JAL);
    assign is_jalr  = (ir_op == OP_JALR);
    assign known    = op_known(ir_op);

    // branch condition from the live ALU flags
    logic taken;
    always_comb begin
        taken = 1'b0;
        case (ir_f3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = less;
            3'b101:  taken = ~less;
            3'b110:  taken = less;
            3'b111:  taken = ~less;
            default: taken = 1'b0;
        endcase
    end

    // state sequencing and instruction register capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            ir_op  <= '0;
            ir_f3  <= '0;
            ir_alt <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (instr_valid) begin
                        ir_op  <= instr[6:0];
                        ir_f3  <= instr[14:12];
                        ir_alt <= instr[30];
                        state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (known)
                        state <= S_EXEC;
                    else
`ifdef RV32_MC_CTRL_TRAP_EN
                        state <= S_TRAP;
`else
                        state <= S_FETCH;
`endif
                end
                S_EXEC: begin
                    if (is_load || is_store)
                        state <= S_MEM;
                    else if (is_br)
                        state <= S_FETCH;
                    else
                        state <= S_WB;
                end
                S_MEM: begin
                    if (mem_done)
                        state <= is_load ? S_WB : S_FETCH;
                end
                S_WB:   state <= S_FETCH;
                S_TRAP: state <= S_TRAP;
                default: state <= S_IDLE;
            endcase
        end
    end

    logic dec_en;
    assign dec_en = (state == S_DECODE) || (state == S_EXEC) ||
                    (state == S_MEM)    || (state == S_WB);

    // output decode from state and IR
    always_comb begin
        instr_ready = (state == S_FETCH);
        busy        = (state != S_IDLE) && (state != S_FETCH);
        alu_ctr     = '0;
        alu_asrc    = 1'b0;
        alu_bsrc    = '0;
        ext_op      = '0;
        reg_wr      = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_to_reg  = 1'b0;
        mem_op      = '0;
        pc_wr       = 1'b0;
        pc_src      = PC_4;
        trap        = 1'b0;
        if (dec_en) begin
            alu_ctr  = dec_ctr;
            alu_asrc = dec_asrc;
            alu_bsrc = dec_bsrc;
            ext_op   = dec_ext;
        end
        case (state)
            S_DECODE: begin
`ifndef RV32_MC_CTRL_TRAP_EN
                if (!known)
                    pc_wr = 1'b1;
`endif
            end
            S_EXEC: begin
                if (is_br) begin
                    pc_wr  = 1'b1;
                    pc_src = taken ? PC_IMM : PC_4;
                end
            end
            S_MEM: begin
                mem_rd = is_load;
                mem_wr = is_store;
                mem_op = ir_f3;
                if (is_store && mem_done)
                    pc_wr = 1'b1;
            end
            S_WB: begin
                reg_wr     = 1'b1;
                pc_wr      = 1'b1;
                mem_to_reg = is_load;
                if (is_load)
                    mem_op = ir_f3;
                if (is_jal)
                    pc_src = PC_IMM;
                else if (is_jalr)
                    pc_src = PC_JR;
            end
            S_TRAP: begin
`ifdef RV32_MC_CTRL_TRAP_EN
                trap = 1'b1;
`endif
            end
            default: begin
                trap = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rv32_mc_ctrl.sv
// Self-checking bench for rv32_mc_ctrl: vector table for
// EXEC decode and latency, plus mem/wb/trap/reset sequences.
module tb_rv32_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_done;
    logic        less;
    logic        zero;
    logic [3:0]  alu_ctr;
    logic        alu_asrc;
    logic [1:0]  alu_bsrc;
    logic [2:0]  ext_op;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_to_reg;
    logic [2:0]  mem_op;
    logic        pc_wr;
    logic [1:0]  pc_src;
    logic        busy;
    logic        trap;

    rv32_mc_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .mem_done    (mem_done),
        .less        (less),
        .zero        (zero),
        .alu_ctr     (alu_ctr),
        .alu_asrc    (alu_asrc),
        .alu_bsrc    (alu_bsrc),
        .ext_op      (ext_op),
        .reg_wr      (reg_wr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_to_reg  (mem_to_reg),
        .mem_op      (mem_op),
        .pc_wr       (pc_wr),
        .pc_src      (pc_src),
        .busy        (busy),
        .trap        (trap)
    );

    always #5 clk = ~clk;

    logic [22:0] outs;
    assign outs = {instr_ready, alu_ctr, alu_asrc, alu_bsrc, ext_op,
                   reg_wr, mem_rd, mem_wr, mem_to_reg, mem_op,
                   pc_wr, pc_src, busy, trap};

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string       nm;
        logic [31:0] ins;
        logic        lss;
        logic        zro;
        logic [3:0]  ctr;
        logic [5:0]  sel;
        logic [2:0]  pc;
        int          lat;
    } vec_t;

    vec_t tv[22];

    function automatic vec_t mk(input string nm, input logic [31:0] ins,
                                input logic lss, input logic zro,
                                input logic [3:0] ctr, input logic [5:0] sel,
                                input logic [2:0] pc, input int lat);
        vec_t v;
        v.nm  = nm;
        v.ins = ins;
        v.lss = lss;
        v.zro = zro;
        v.ctr = ctr;
        v.sel = sel;
        v.pc  = pc;
        v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_fetch();
        int k = 0;
        while (!instr_ready && k < 20) begin
            step();
            k++;
        end
        chk("fetch_ready", 32'(instr_ready), 32'd1);
    endtask

    // handshake one word; returns with the DUT in DECODE
    task automatic issue(input logic [31:0] w);
        wait_fetch();
        instr       = w;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        less     = v.lss;
        zero     = v.zro;
        mem_done = 1'b1;
        issue(v.ins);
        chk({v.nm, "_dec"}, 32'({instr_ready, busy}), 32'b01);
        step();
        chk({v.nm, "_ctr"}, 32'(alu_ctr), 32'(v.ctr));
        chk({v.nm, "_sel"}, 32'({alu_asrc, alu_bsrc, ext_op}), 32'(v.sel));
        chk({v.nm, "_pc"}, 32'({pc_wr, pc_src}), 32'(v.pc));
        n = 1;
        while (!instr_ready && n < 20) begin
            step();
            n++;
        end
        chk({v.nm, "_lat"}, 32'(n), 32'(v.lat));
        mem_done = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        mem_done    = 1'b0;
        less        = 1'b0;
        zero        = 1'b0;

        tv[0]  = mk("add",    32'h002081B3, 0, 0, 4'b0000, 6'b0_00_000, 3'b000, 3);
        tv[1]  = mk("sub",    32'h402081B3, 0, 0, 4'b1000, 6'b0_00_000, 3'b000, 3);
        tv[2]  = mk("sra",    32'h4020D1B3, 0, 0, 4'b1101, 6'b0_00_000, 3'b000, 3);
        tv[3]  = mk("sltu",   32'h0020B1B3, 0, 0, 4'b1010, 6'b0_00_000, 3'b000, 3);
        tv[4]  = mk("slt",    32'h0020A1B3, 0, 0, 4'b0010, 6'b0_00_000, 3'b000, 3);
        tv[5]  = mk("and",    32'h0020F1B3, 0, 0, 4'b0111, 6'b0_00_000, 3'b000, 3);
        tv[6]  = mk("addi30", 32'h40000093, 0, 0, 4'b0000, 6'b0_01_000, 3'b000, 3);
        tv[7]  = mk("srai",   32'h4030D093, 0, 0, 4'b1101, 6'b0_01_000, 3'b000, 3);
        tv[8]  = mk("xori",   32'h0010C093, 0, 0, 4'b0100, 6'b0_01_000, 3'b000, 3);
        tv[9]  = mk("lui",    32'h123452B7, 0, 0, 4'b0011, 6'b0_01_001, 3'b000, 3);
        tv[10] = mk("auipc",  32'h00001297, 0, 0, 4'b0000, 6'b1_01_001, 3'b000, 3);
        tv[11] = mk("jal",    32'h008000EF, 0, 0, 4'b0000, 6'b1_10_100, 3'b000, 3);
        tv[12] = mk("jalr",   32'h00008067, 0, 0, 4'b0000, 6'b1_10_000, 3'b000, 3);
        tv[13] = mk("beq_t",  32'h00208463, 0, 1, 4'b0010, 6'b0_00_011, 3'b101, 2);
        tv[14] = mk("bne_t",  32'h00209463, 0, 0, 4'b0010, 6'b0_00_011, 3'b101, 2);
        tv[15] = mk("bne_nt", 32'h00209463, 0, 1, 4'b0010, 6'b0_00_011, 3'b100, 2);
        tv[16] = mk("blt_t",  32'h0020C463, 1, 0, 4'b0010, 6'b0_00_011, 3'b101, 2);
        tv[17] = mk("bge_nt", 32'h0020D463, 1, 0, 4'b0010, 6'b0_00_011, 3'b100, 2);
        tv[18] = mk("bltu_t", 32'h0020E463, 1, 0, 4'b1010, 6'b0_00_011, 3'b101, 2);
        tv[19] = mk("bgeu_t", 32'h0020F463, 0, 0, 4'b1010, 6'b0_00_011, 3'b101, 2);
        tv[20] = mk("lw",     32'h0040A283, 0, 0, 4'b0000, 6'b0_01_000, 3'b000, 4);
        tv[21] = mk("sw",     32'h0050A223, 0, 0, 4'b0000, 6'b0_01_010, 3'b000, 3);

        // reset state and release into IDLE then FETCH
        step();
        step();
        chk("reset_outs", 32'(outs), 32'd0);
        rst_n = 1'b1;
        chk("idle_ready", 32'({instr_ready, busy}), 32'b00);
        step();
        chk("fetch_ready0", 32'({instr_ready, busy}), 32'b10);

        for (int i = 0; i < 22; i++)
            run_vec(tv[i]);

        // add: WB strobes
        issue(32'h002081B3);
        step();
        step();
        chk("add_wb", 32'({reg_wr, pc_wr, pc_src, mem_to_reg}), 32'b11000);

        // jal/jalr: WB uses the jump source
        issue(32'h008000EF);
        step();
        step();
        chk("jal_wb", 32'({reg_wr, pc_wr, pc_src}), 32'b1101);
        issue(32'h00008067);
        step();
        step();
        chk("jalr_wb", 32'({reg_wr, pc_wr, pc_src}), 32'b1110);

        // lw with three wait cycles; valid during MEM is ignored
        issue(32'h0040A283);
        mem_done = 1'b0;
        step();
        step();
        instr       = 32'h002081B3;
        instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("lw_mem", 32'({mem_rd, mem_wr, mem_op, instr_ready}), 32'b10_010_0);
            if (i == 3) begin
                mem_done    = 1'b1;
                instr_valid = 1'b0;
            end
            step();
        end
        mem_done = 1'b0;
        chk("lw_wb", 32'({reg_wr, pc_wr, mem_to_reg, pc_src, mem_rd}), 32'b111000);
        step();
        chk("lw_done", 32'(instr_ready), 32'd1);

        // sw: pc_wr only with mem_done, no WB
        issue(32'h0050A223);
        step();
        step();
        chk("sw_wait", 32'({mem_wr, pc_wr, mem_rd}), 32'b100);
        mem_done = 1'b1;
        #1;
        chk("sw_done", 32'({mem_wr, pc_wr, pc_src, reg_wr}), 32'b11000);
        step();
        mem_done = 1'b0;
        chk("sw_nowb", 32'({instr_ready, reg_wr}), 32'b10);

        // unknown opcode 0x00
        issue(32'h00000000);
`ifdef RV32_MC_CTRL_TRAP_EN
        step();
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("trap_hold", 32'({trap, instr_ready, busy, pc_wr, reg_wr}), 32'b10100);
            step();
        end
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("trap_rst", 32'(outs), 32'd0);
        step();
        rst_n = 1'b1;
        step();
`else
        chk("nop_dec", 32'({pc_wr, pc_src, busy, trap}), 32'b10010);
        step();
        chk("nop_fetch", 32'({instr_ready, trap}), 32'b10);
`endif

        // reset asserted in MEM aborts immediately
        issue(32'h0040A283);
        mem_done = 1'b0;
        step();
        step();
        chk("mid_mem", 32'(mem_rd), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst", 32'(outs), 32'd0);
        step();
        chk("mid_rst_hold", 32'(outs), 32'd0);
        rst_n = 1'b1;
        chk("post_idle", 32'({instr_ready, busy}), 32'b00);
        step();
        chk("post_fetch", 32'({instr_ready, busy, mem_rd}), 32'b100);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
